prog_sequencer: RTL and testbench
=================================

// Module: prog_sequencer
// PURPOSE
//  Run controller directly upstream of the processor core. Drives the core's
//  start (init) input and selects the program image (prog_sel to InstROM bank).
//  Watches the core's halt flag and measures each run's cycle count.
//  Runs NUM_PROGS programs back to back on a single host go pulse.
// PARAMETERS
//  START_CYCLES  2      cycles start is held high per launch (>=1)
//  NUM_PROGS     3      programs per sequence, index 0..NUM_PROGS-1
//  PSW           2      prog_sel width, 2**PSW >= NUM_PROGS
//  CNT_W         16     cycle counter width (matches core cycle_ct)
//  TIMEOUT       16'hFFFF  watchdog limit in RUN cycles (macro builds only)
// PORTS
//  CLK        in   1      clock, posedge
//  reset      in   1      async, active-high
//  go         in   1      host request: start a full sequence (level sampled)
//  halt       in   1      done flag from core
//  start      out  1      init to core, active high
//  prog_sel   out  PSW    program index currently launched/running
//  busy       out  1      high from accepted go until done pulse (inclusive)
//  done       out  1      1-cycle pulse: all programs recorded
//  cyc_valid  out  1      1-cycle pulse: cyc_count/cyc_prog valid
//  cyc_count  out  CNT_W  RUN cycles of the finished program
//  cyc_prog   out  PSW    index the cyc_count belongs to
//  timeout    out  1      sticky watchdog flag (0 without macro)
// BEHAVIOUR
//  Reset (async): state=IDLE; start=0, prog_sel=0, busy=0, done=0,
//   cyc_valid=0, cyc_count=0, cyc_prog=0, timeout=0; counters cleared.
//   Reset mid-run aborts immediately; no partial record emitted.
//  States: IDLE -> LAUNCH -> RUN -> RECORD -> (LAUNCH | FIN) ; FIN -> IDLE.
//  IDLE: go=1 -> LAUNCH next cycle, busy=1, prog_sel=0. go=0 stays.
//  LAUNCH: start=1 for exactly START_CYCLES cycles, then RUN. cnt cleared.
//  RUN: start=0. cnt increments every RUN cycle, saturates at 2**CNT_W-1.
//   halt ignored in first RUN cycle (stale halt from prior program);
//   halt=1 in any later RUN cycle -> RECORD; that cycle is counted.
//  RECORD (1 cycle): cyc_valid=1, cyc_count=cnt, cyc_prog=prog_sel.
//   cyc_count/cyc_prog hold until next RECORD or reset.
//   prog_sel==NUM_PROGS-1 -> FIN; else prog_sel+1, -> LAUNCH.
//  FIN (1 cycle): done=1, busy=1; -> IDLE (busy=0 next cycle).
//  go while busy (incl. FIN) ignored; go held high through FIN starts a
//   new sequence from IDLE on the following cycle.
//  Latency: go edge to first start=1 = 1 cycle; halt to cyc_valid = 1 cycle.
//  timeout cleared only by reset or by an accepted go.
// CONFIGURATION
//  `SEQ_TIMEOUT_EN defined: in RUN, if cnt reaches TIMEOUT without halt,
//   -> RECORD with cyc_count=TIMEOUT, timeout set to 1, sequence continues
//   with next program. halt and timeout same cycle: halt wins, no flag.
//  Not defined: no watchdog; RUN waits indefinitely for halt; timeout=0;
//   TIMEOUT parameter unused.
// TESTING
//  Reset assert mid-RUN -> all outputs 0 same cycle, IDLE; go later restarts at prog 0.
//  go=1, halts after 10/20/30 RUN cycles, START_CYCLES=2 -> start high 2 cycles
//   per launch; cyc_valid x3 with (0,10),(1,20),(2,30); done 1 cycle after last.
//  halt held 1 across LAUNCH and first RUN cycle, low 2nd, high 5th -> count=5.
//  go pulsed during RUN of prog 1 -> ignored; exactly 3 records, one done.
//  CNT_W=4, halt at RUN cycle 20 -> cyc_count=15 (saturated).
//  With SEQ_TIMEOUT_EN, TIMEOUT=8, prog 1 never halts -> record (1,8),
//   timeout=1, prog 2 launched; next go clears timeout.

Source files
------------

// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
//
// Run controller that sits directly upstream of the processor core. A single
// host go request runs NUM_PROGS programs back to back. For each program the
// sequencer:
//   - selects the program image (prog_sel_o drives the InstROM bank select),
//   - pulses the core's init input (start_o) for START_CYCLES cycles,
//   - counts RUN cycles until the core raises halt_i,
//   - publishes a one-cycle record (cyc_valid_o, cyc_count_o, cyc_prog_o).
// After the last program a one-cycle done_o pulse closes the sequence.
//
// Optional build feature:
//   SEQ_TIMEOUT_EN  when defined, a watchdog ends any RUN phase whose cycle
//                   count reaches TIMEOUT without a halt. The program is
//                   recorded with cyc_count_o = TIMEOUT, the sticky timeout_o
//                   flag is raised, and the sequence moves on to the next
//                   program. When undefined, RUN waits for halt indefinitely,
//                   timeout_o is tied low and TIMEOUT has no effect.
//
// Parameters:
//   START_CYCLES  cycles start_o is held high per launch (>= 1)
//   NUM_PROGS     programs per sequence, indices 0 .. NUM_PROGS-1
//   PSW           prog_sel width, 2**PSW >= NUM_PROGS
//   CNT_W         cycle counter width (matches the core's cycle counter)
//   TIMEOUT       watchdog limit in RUN cycles (watchdog builds only)
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous reset, active high
//   go_i          host request to run a full sequence (level sampled in IDLE)
//   halt_i        done flag from the core
//   start_o       init to the core, active high
//   prog_sel_o    index of the program currently launched / running
//   busy_o        high from the accepted go until the done pulse, inclusive
//   done_o        one-cycle pulse once every program has been recorded
//   cyc_valid_o   one-cycle pulse, cyc_count_o / cyc_prog_o are fresh
//   cyc_count_o   RUN cycles of the program that just finished
//   cyc_prog_o    program index that cyc_count_o belongs to
//   timeout_o     sticky watchdog flag (always 0 without SEQ_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module prog_sequencer #(
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned NUM_PROGS    = 3,
  parameter int unsigned PSW          = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned TIMEOUT      = 32'h0000_FFFF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_i,
  input  logic             halt_i,
  output logic             start_o,
  output logic [PSW-1:0]   prog_sel_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cyc_valid_o,
  output logic [CNT_W-1:0] cyc_count_o,
  output logic [PSW-1:0]   cyc_prog_o,
  output logic             timeout_o
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // ---------------------------------------------------------------------------
  if (START_CYCLES < 1) begin : g_bad_start_cycles
    $error("prog_sequencer: START_CYCLES must be at least 1");
  end
  if (NUM_PROGS < 1 || (2 ** PSW) < NUM_PROGS) begin : g_bad_num_progs
    $error("prog_sequencer: NUM_PROGS must be 1 .. 2**PSW");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("prog_sequencer: CNT_W must be 1 .. 32");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("prog_sequencer: TIMEOUT must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  localparam int unsigned LCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [LCW-1:0] LAUNCH_LAST = LCW'(START_CYCLES - 1);
  localparam logic [PSW-1:0] LAST_PROG   = PSW'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_RECORD,
    S_FIN
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [LCW-1:0]   lcnt_q, lcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PSW-1:0]   prog_sel_q, prog_sel_d;
  logic [CNT_W-1:0] cyc_count_q, cyc_count_d;
  logic [PSW-1:0]   cyc_prog_q, cyc_prog_d;

  // Saturating increment of the RUN counter. This is the count that includes
  // the current RUN cycle, so it is also what gets recorded on halt.
  logic [CNT_W-1:0] cnt_inc;
  // The counter is cleared in LAUNCH and never wraps back to zero, so a zero
  // count identifies the first RUN cycle, where a halt left over from the
  // previous program must be ignored.
  logic             first_run;

  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign first_run = (cnt_q == '0);

`ifdef SEQ_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic wdog_hit;

  // Compared at 32 bits so a TIMEOUT beyond the counter range simply never
  // fires instead of aliasing onto a smaller count.
  assign wdog_hit = (32'(cnt_inc) == TIMEOUT);
`endif

  // ---------------------------------------------------------------------------
  // Register update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      lcnt_q      <= '0;
      cnt_q       <= '0;
      prog_sel_q  <= '0;
      cyc_count_q <= '0;
      cyc_prog_q  <= '0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      cnt_q       <= cnt_d;
      prog_sel_q  <= prog_sel_d;
      cyc_count_q <= cyc_count_d;
      cyc_prog_q  <= cyc_prog_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    cnt_d       = cnt_q;
    prog_sel_d  = prog_sel_q;
    cyc_count_d = cyc_count_q;
    cyc_prog_d  = cyc_prog_q;
`ifdef SEQ_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (go_i) begin
          state_d    = S_LAUNCH;
          prog_sel_d = '0;
          lcnt_d     = '0;
`ifdef SEQ_TIMEOUT_EN
          // An accepted go starts a fresh sequence with a clean flag.
          timeout_d  = 1'b0;
`endif
        end
      end

      S_LAUNCH: begin
        cnt_d = '0;
        if (lcnt_q == LAUNCH_LAST) begin
          state_d = S_RUN;
          lcnt_d  = '0;
        end else begin
          lcnt_d  = lcnt_q + 1'b1;
        end
      end

      S_RUN: begin
        cnt_d = cnt_inc;
        // A real halt takes priority over the watchdog firing in the
        // same cycle, and then the timeout flag is left alone.
        if (halt_i && !first_run) begin
          state_d     = S_RECORD;
          cyc_count_d = cnt_inc;
          cyc_prog_d  = prog_sel_q;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wdog_hit) begin
          state_d     = S_RECORD;
          cyc_count_d = cnt_inc;
          cyc_prog_d  = prog_sel_q;
          timeout_d   = 1'b1;
        end
`endif
      end

      S_RECORD: begin
        if (prog_sel_q == LAST_PROG) begin
          state_d    = S_FIN;
        end else begin
          state_d    = S_LAUNCH;
          prog_sel_d = prog_sel_q + 1'b1;
          lcnt_d     = '0;
        end
      end

      S_FIN: begin
        // Return the bank select to program 0 so IDLE looks like reset.
        state_d    = S_IDLE;
        prog_sel_d = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so every output drops to
  // its reset value in the same cycle an asynchronous reset is asserted.
  // ---------------------------------------------------------------------------
  assign start_o     = (state_q == S_LAUNCH);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FIN);
  assign cyc_valid_o = (state_q == S_RECORD);
  assign prog_sel_o  = prog_sel_q;
  assign cyc_count_o = cyc_count_q;
  assign cyc_prog_o  = cyc_prog_q;

`ifdef SEQ_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// -----------------------------------------------------------------------------
// tb_prog_sequencer
//
// Self-checking bench for prog_sequencer. Three instances share one set of
// stimulus drivers, selected by 'sel':
//   0: A  default configuration (CNT_W=16, TIMEOUT=16'hFFFF)
//   1: B  CNT_W=4, exercises counter saturation
//   2: C  TIMEOUT=8, exercises the watchdog when SEQ_TIMEOUT_EN is defined
// A per-cycle vector table covers the basic flow on A; hand-written program
// runs cover the longer multi-cycle cases.
// -----------------------------------------------------------------------------
module tb_prog_sequencer;

  logic clk;
  logic rstA, rstB, rstC;
  logic goDrv, haltDrv;
  int   sel;

  int nCompared;
  int nFailed;
  int recCnt;
  int doneCnt;

  logic goA, goB, goC, haltA, haltB, haltC;

  logic        startA, busyA, doneA, validA, tmoA;
  logic [1:0]  pselA, cprogA;
  logic [15:0] cntA;

  logic        startB, busyB, doneB, validB, tmoB;
  logic [1:0]  pselB, cprogB;
  logic [3:0]  cntB;

  logic        startC, busyC, doneC, validC, tmoC;
  logic [1:0]  pselC, cprogC;
  logic [15:0] cntC;

  logic        obsStart, obsBusy, obsDone, obsValid, obsTmo;
  logic [1:0]  obsPsel, obsCprog;
  logic [15:0] obsCnt;
  logic [31:0] obsVec;

  typedef struct {
    logic        go;
    logic        halt;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  assign goA   = goDrv   && (sel == 0);
  assign goB   = goDrv   && (sel == 1);
  assign goC   = goDrv   && (sel == 2);
  assign haltA = haltDrv && (sel == 0);
  assign haltB = haltDrv && (sel == 1);
  assign haltC = haltDrv && (sel == 2);

  prog_sequencer #(
    .START_CYCLES(2), .NUM_PROGS(3), .PSW(2), .CNT_W(16), .TIMEOUT(32'h0000_FFFF)
  ) dutA (
    .clk_i(clk), .rst_i(rstA), .go_i(goA), .halt_i(haltA),
    .start_o(startA), .prog_sel_o(pselA), .busy_o(busyA), .done_o(doneA),
    .cyc_valid_o(validA), .cyc_count_o(cntA), .cyc_prog_o(cprogA),
    .timeout_o(tmoA)
  );

  prog_sequencer #(
    .START_CYCLES(2), .NUM_PROGS(3), .PSW(2), .CNT_W(4), .TIMEOUT(32'h0000_FFFF)
  ) dutB (
    .clk_i(clk), .rst_i(rstB), .go_i(goB), .halt_i(haltB),
    .start_o(startB), .prog_sel_o(pselB), .busy_o(busyB), .done_o(doneB),
    .cyc_valid_o(validB), .cyc_count_o(cntB), .cyc_prog_o(cprogB),
    .timeout_o(tmoB)
  );

  prog_sequencer #(
    .START_CYCLES(2), .NUM_PROGS(3), .PSW(2), .CNT_W(16), .TIMEOUT(8)
  ) dutC (
    .clk_i(clk), .rst_i(rstC), .go_i(goC), .halt_i(haltC),
    .start_o(startC), .prog_sel_o(pselC), .busy_o(busyC), .done_o(doneC),
    .cyc_valid_o(validC), .cyc_count_o(cntC), .cyc_prog_o(cprogC),
    .timeout_o(tmoC)
  );

  // Route the selected instance onto a common set of observation signals.
  always_comb begin
    obsStart = startA; obsBusy = busyA; obsDone = doneA; obsValid = validA;
    obsTmo = tmoA; obsPsel = pselA; obsCprog = cprogA; obsCnt = cntA;
    if (sel == 1) begin
      obsStart = startB; obsBusy = busyB; obsDone = doneB; obsValid = validB;
      obsTmo = tmoB; obsPsel = pselB; obsCprog = cprogB; obsCnt = {12'b0, cntB};
    end else if (sel == 2) begin
      obsStart = startC; obsBusy = busyC; obsDone = doneC; obsValid = validC;
      obsTmo = tmoC; obsPsel = pselC; obsCprog = cprogC; obsCnt = cntC;
    end
  end

  assign obsVec = {7'b0, obsStart, obsBusy, obsDone, obsValid, obsTmo,
                   obsPsel, obsCprog, obsCnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count record and done pulses of the selected instance.
  always @(negedge clk) begin
    if (obsValid) recCnt++;
    if (obsDone)  doneCnt++;
  end

  function automatic logic [31:0] mkExp(input logic st, input logic bz,
                                        input logic dn, input logic vl,
                                        input logic to, input logic [1:0] ps,
                                        input logic [1:0] cp,
                                        input logic [15:0] cc);
    return {7'b0, st, bz, dn, vl, to, ps, cp, cc};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs for the coming cycle, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic go, input logic halt);
    goDrv   = go;
    haltDrv = halt;
    @(posedge clk);
    #1;
  endtask

  // Core stand-in for one program: waits for the launch, measures the start
  // pulse, holds RUN for runLen cycles raising halt at cycle haltAt (0 = never),
  // optionally pulses go at RUN cycle goAt, optionally holds a stale halt
  // through LAUNCH and the first RUN cycle, then checks the record.
  task automatic runProgram(input int runLen, input int haltAt,
                            input int expCount, input int expProg,
                            input int goAt, input logic stale);
    int w;
    int n;
    w = 0;
    n = 0;
    while (!obsStart && w < 20) begin
      applyStimulus(1'b0, stale);
      w++;
    end
    checkOutput("launch_seen", 32'(obsStart), 32'd1);
    checkOutput("launch_prog", 32'(obsPsel), 32'(expProg));
    while (obsStart && n < 10) begin
      applyStimulus(1'b0, stale);
      n++;
    end
    checkOutput("start_len", 32'(n), 32'd2);
    for (int k = 1; k <= runLen; k++) begin
      applyStimulus(k == goAt, (k == haltAt) || (stale && k == 1));
    end
    goDrv   = 1'b0;
    haltDrv = 1'b0;
    checkOutput("rec_valid", 32'(obsValid), 32'd1);
    checkOutput("rec_count", 32'(obsCnt), 32'(expCount));
    checkOutput("rec_prog", 32'(obsCprog), 32'(expProg));
  endtask

  task automatic finishSeq();
    applyStimulus(1'b0, 1'b0);
    checkOutput("fin_done", 32'({obsDone, obsBusy}), 32'b11);
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle_after_fin", 32'({obsDone, obsBusy}), 32'b00);
  endtask

  initial begin
    nCompared = 0;
    nFailed   = 0;
    recCnt    = 0;
    doneCnt   = 0;
    sel       = 0;
    goDrv     = 1'b0;
    haltDrv   = 1'b0;
    rstA      = 1'b1;
    rstB      = 1'b1;
    rstC      = 1'b1;

    //             go    halt  start busy done valid tmo psel cprog count
    vecs[0]  = '{1'b1, 1'b0, mkExp(0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0)};
    vecs[1]  = '{1'b0, 1'b0, mkExp(1, 1, 0, 0, 0, 2'd0, 2'd0, 16'd0)};
    vecs[2]  = '{1'b0, 1'b0, mkExp(1, 1, 0, 0, 0, 2'd0, 2'd0, 16'd0)};
    vecs[3]  = '{1'b0, 1'b0, mkExp(0, 1, 0, 0, 0, 2'd0, 2'd0, 16'd0)};
    vecs[4]  = '{1'b0, 1'b1, mkExp(0, 1, 0, 0, 0, 2'd0, 2'd0, 16'd0)};
    vecs[5]  = '{1'b0, 1'b1, mkExp(0, 1, 0, 1, 0, 2'd0, 2'd0, 16'd2)};
    vecs[6]  = '{1'b0, 1'b1, mkExp(1, 1, 0, 0, 0, 2'd1, 2'd0, 16'd2)};
    vecs[7]  = '{1'b0, 1'b0, mkExp(1, 1, 0, 0, 0, 2'd1, 2'd0, 16'd2)};
    vecs[8]  = '{1'b0, 1'b0, mkExp(0, 1, 0, 0, 0, 2'd1, 2'd0, 16'd2)};
    vecs[9]  = '{1'b1, 1'b0, mkExp(0, 1, 0, 0, 0, 2'd1, 2'd0, 16'd2)};
    vecs[10] = '{1'b0, 1'b1, mkExp(0, 1, 0, 0, 0, 2'd1, 2'd0, 16'd2)};
    vecs[11] = '{1'b0, 1'b0, mkExp(0, 1, 0, 1, 0, 2'd1, 2'd1, 16'd3)};
    vecs[12] = '{1'b0, 1'b0, mkExp(1, 1, 0, 0, 0, 2'd2, 2'd1, 16'd3)};
    vecs[13] = '{1'b0, 1'b0, mkExp(1, 1, 0, 0, 0, 2'd2, 2'd1, 16'd3)};
    vecs[14] = '{1'b0, 1'b1, mkExp(0, 1, 0, 0, 0, 2'd2, 2'd1, 16'd3)};
    vecs[15] = '{1'b0, 1'b1, mkExp(0, 1, 0, 0, 0, 2'd2, 2'd1, 16'd3)};
    vecs[16] = '{1'b0, 1'b0, mkExp(0, 1, 0, 1, 0, 2'd2, 2'd2, 16'd2)};
    vecs[17] = '{1'b1, 1'b0, mkExp(0, 1, 1, 0, 0, 2'd2, 2'd2, 16'd2)};
    vecs[18] = '{1'b1, 1'b0, mkExp(0, 0, 0, 0, 0, 2'd0, 2'd2, 16'd2)};
    vecs[19] = '{1'b0, 1'b0, mkExp(1, 1, 0, 0, 0, 2'd0, 2'd2, 16'd2)};

    repeat (2) @(posedge clk);
    #1;
    rstA = 1'b0;
    rstB = 1'b0;
    rstC = 1'b0;

    // Per-cycle table on A: stale halt, go while busy, go held through FIN.
    for (int i = 0; i < NV; i++) begin
      checkOutput($sformatf("vec%0d", i), obsVec, vecs[i].exp);
      applyStimulus(vecs[i].go, vecs[i].halt);
    end

    // Reset asserted mid-RUN clears every output at once.
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("pre_reset_busy", 32'({obsStart, obsBusy}), 32'b01);
    #2;
    rstA = 1'b1;
    #1;
    checkOutput("reset_outputs", obsVec, 32'd0);
    rstA = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_reset_idle", obsVec, 32'd0);

    // Full sequence 10/20/30 with a go pulse during RUN of program 1.
    recCnt  = 0;
    doneCnt = 0;
    applyStimulus(1'b1, 1'b0);
    runProgram(10, 10, 10, 0, 0, 1'b0);
    runProgram(20, 20, 20, 1, 5, 1'b0);
    runProgram(30, 30, 30, 2, 0, 1'b0);
    finishSeq();
    applyStimulus(1'b0, 1'b0);
    checkOutput("record_count", 32'(recCnt), 32'd3);
    checkOutput("done_count", 32'(doneCnt), 32'd1);

    // Stale halt held across LAUNCH and the first RUN cycle.
    applyStimulus(1'b1, 1'b0);
    runProgram(5, 5, 5, 0, 0, 1'b1);
    runProgram(2, 2, 2, 1, 0, 1'b0);
    runProgram(3, 3, 3, 2, 0, 1'b0);
    finishSeq();

    // Counter saturation with a 4-bit counter.
    sel = 1;
    applyStimulus(1'b1, 1'b0);
    runProgram(20, 20, 15, 0, 0, 1'b0);
    rstB = 1'b1;
    applyStimulus(1'b0, 1'b0);
    rstB = 1'b0;

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: program 1 never halts, then a halt exactly at the limit.
    sel = 2;
    applyStimulus(1'b1, 1'b0);
    runProgram(3, 3, 3, 0, 0, 1'b0);
    runProgram(8, 0, 8, 1, 0, 1'b0);
    checkOutput("tmo_set", 32'(obsTmo), 32'd1);
    runProgram(2, 2, 2, 2, 0, 1'b0);
    finishSeq();
    checkOutput("tmo_sticky", 32'(obsTmo), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("tmo_cleared", 32'(obsTmo), 32'd0);
    runProgram(8, 8, 8, 0, 0, 1'b0);
    checkOutput("tmo_halt_wins", 32'(obsTmo), 32'd0);
    rstC = 1'b1;
    applyStimulus(1'b0, 1'b0);
    rstC = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
